// File: rtl/mem_burst_ctrl_if.sv
// mem_burst_ctrl_if
// Bundles every handshake and data signal of mem_burst_ctrl: the command
// port, the write-data stream, the read-data stream, status, and the banked
// memory bus toward memory_wrapper.
//   master : the burst controller (drives the memory bus, status, streams out)
//   slave  : the environment (command source, write source, memory banks)
// Parameters: NUM_MEMS banks, WIDTH bits per bank, ADDR_SIZE address bits.
interface mem_burst_ctrl_if #(
    parameter int NUM_MEMS  = 4,
    parameter int WIDTH     = 16,
    parameter int ADDR_SIZE = 9
);
    logic                        cmd_valid;
    logic                        cmd_ready;
    logic                        cmd_wr_rd;
    logic [ADDR_SIZE-1:0]        cmd_addr;
    logic [ADDR_SIZE-1:0]        cmd_len;

    logic                        wr_valid;
    logic                        wr_ready;
    logic [NUM_MEMS*WIDTH-1:0]   wr_data;

    logic                        rd_valid;
    logic [NUM_MEMS*WIDTH-1:0]   rd_data;

    logic                        busy;
    logic                        done;
    logic                        err;

    logic [ADDR_SIZE-1:0]        mem_addr;
    logic                        mem_wr_rd;
    logic [NUM_MEMS*WIDTH-1:0]   mem_wdata;
    logic [NUM_MEMS*WIDTH-1:0]   mem_rdata;
    logic [NUM_MEMS-1:0]         mem_valid;
    logic [NUM_MEMS-1:0]         mem_ready;

    modport master (
        input  cmd_valid, cmd_wr_rd, cmd_addr, cmd_len,
        input  wr_valid, wr_data,
        input  mem_rdata, mem_ready,
        output cmd_ready, wr_ready, rd_valid, rd_data,
        output busy, done, err,
        output mem_addr, mem_wr_rd, mem_wdata, mem_valid
    );

    modport slave (
        output cmd_valid, cmd_wr_rd, cmd_addr, cmd_len,
        output wr_valid, wr_data,
        output mem_rdata, mem_ready,
        input  cmd_ready, wr_ready, rd_valid, rd_data,
        input  busy, done, err,
        input  mem_addr, mem_wr_rd, mem_wdata, mem_valid
    );
endinterface

// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl
// Burst sequencer for the banked memory_wrapper. Takes a start address, a
// beat count (len = beats-1) and a direction, then walks the address range
// one beat at a time using the per-bank valid/ready handshake. Write beats
// come from a streaming source (wr_valid/wr_ready); read beats leave as a
// one-cycle rd_valid strobe with no backpressure.
// Ports:
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : mem_burst_ctrl_if.master (command, write stream, read stream,
//              busy/done/err status, memory bus toward memory_wrapper)
// Optional feature macro: MEM_BURST_TIMEOUT_EN -- per-beat ack timeout of
// TIMEOUT cycles; on expiry the burst aborts with done and err together.
// Without it err is tied low and XFER waits indefinitely for acks.
//
// State table
//   state | meaning
//   IDLE  | cmd_ready high, waiting for a command
//   FETCH | write burst: wr_ready high, waiting for the next write beat
//   XFER  | mem_valid raised on every bank not yet acked for this beat
//   DONE  | done (and err on timeout) pulsed for one cycle
module mem_burst_ctrl #(
    parameter int NUM_MEMS  = 4,
    parameter int WIDTH     = 16,
    parameter int ADDR_SIZE = 9,
    parameter int DEPTH     = 512,
    parameter int TIMEOUT   = 255
) (
    input logic              clk,
    input logic              rst,
    mem_burst_ctrl_if.master bus
);

    if (DEPTH < 1 || DEPTH > (1 << ADDR_SIZE) || TIMEOUT < 1) begin : g_cfg_check
        $error("mem_burst_ctrl: DEPTH must be 1..2**ADDR_SIZE and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        XFER  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(DEPTH - 1);
    localparam logic [ADDR_SIZE:0]   ONE_LEFT  = (ADDR_SIZE + 1)'(1);

    state_t               state;
    logic [NUM_MEMS-1:0]  ack_mask;
    logic [ADDR_SIZE:0]   remaining;
    logic [NUM_MEMS-1:0]  ack_now;
    logic                 beat_done;
    logic [ADDR_SIZE-1:0] addr_next;
    logic                 tmo_hit;

    assign ack_now   = bus.mem_valid & bus.mem_ready;
    assign beat_done = (state == XFER) && (&(ack_mask | ack_now));
    // DEPTH need not be a power of two, so the wrap is an explicit compare.
    assign addr_next = (bus.mem_addr == LAST_ADDR) ? '0 : bus.mem_addr + 1'b1;

`ifdef MEM_BURST_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             err_q;

    // Down-counter reloaded outside XFER and on every completed beat; the
    // terminal count with the ack mask still incomplete aborts the burst.
    assign tmo_hit = (state == XFER) && !beat_done && (tmo_cnt == '0);
    assign bus.err = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= TMO_W'(TIMEOUT - 1);
            err_q   <= 1'b0;
        end else begin
            err_q <= tmo_hit;
            if (state != XFER || beat_done) begin
                tmo_cnt <= TMO_W'(TIMEOUT - 1);
            end else if (tmo_cnt != '0) begin
                tmo_cnt <= tmo_cnt - 1'b1;
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            ack_mask      <= '0;
            remaining     <= '0;
            bus.cmd_ready <= 1'b1;
            bus.wr_ready  <= 1'b0;
            bus.rd_valid  <= 1'b0;
            bus.rd_data   <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wr_rd <= 1'b0;
            bus.mem_wdata <= '0;
            bus.mem_valid <= '0;
        end else begin
            bus.done     <= 1'b0;
            bus.rd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        bus.mem_wr_rd <= bus.cmd_wr_rd;
                        bus.mem_addr  <= bus.cmd_addr;
                        remaining     <= {1'b0, bus.cmd_len} + 1'b1;
                        ack_mask      <= '0;
                        bus.cmd_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                        if (bus.cmd_wr_rd) begin
                            bus.wr_ready <= 1'b1;
                            state        <= FETCH;
                        end else begin
                            bus.mem_valid <= '1;
                            state         <= XFER;
                        end
                    end
                end
                FETCH: begin
                    if (bus.wr_valid) begin
                        bus.mem_wdata <= bus.wr_data;
                        bus.wr_ready  <= 1'b0;
                        bus.mem_valid <= '1;
                        state         <= XFER;
                    end
                end
                XFER: begin
                    if (tmo_hit) begin
                        bus.mem_valid <= '0;
                        ack_mask      <= '0;
                        bus.done      <= 1'b1;
                        state         <= DONE;
                    end else begin
                        // Each bank's read slice is captured on its own ack edge,
                        // so staggered banks still assemble one complete beat.
                        for (int k = 0; k < NUM_MEMS; k++) begin
                            if (ack_now[k] && !bus.mem_wr_rd) begin
                                bus.rd_data[k*WIDTH +: WIDTH] <= bus.mem_rdata[k*WIDTH +: WIDTH];
                            end
                        end
                        if (beat_done) begin
                            ack_mask     <= '0;
                            remaining    <= remaining - 1'b1;
                            bus.mem_addr <= addr_next;
                            bus.rd_valid <= !bus.mem_wr_rd;
                            if (remaining == ONE_LEFT) begin
                                bus.mem_valid <= '0;
                                bus.done      <= 1'b1;
                                state         <= DONE;
                            end else if (bus.mem_wr_rd) begin
                                bus.mem_valid <= '0;
                                bus.wr_ready  <= 1'b1;
                                state         <= FETCH;
                            end else begin
                                bus.mem_valid <= '1;
                            end
                        end else begin
                            ack_mask      <= ack_mask | ack_now;
                            bus.mem_valid <= bus.mem_valid & ~ack_now;
                        end
                    end
                end
                DONE: begin
                    bus.busy      <= 1'b0;
                    bus.cmd_ready <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
module tb_mem_burst_ctrl;
    localparam int NM    = 4;
    localparam int W     = 16;
    localparam int AS    = 9;
    localparam int DEPTH = 512;
    localparam int BW    = NM * W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_burst_ctrl_if #(.NUM_MEMS(NM), .WIDTH(W), .ADDR_SIZE(AS)) bus();

    mem_burst_ctrl #(
        .NUM_MEMS(NM), .WIDTH(W), .ADDR_SIZE(AS), .DEPTH(DEPTH), .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [BW-1:0] data;
        int            gap;
    } wbeat_t;

    logic [BW-1:0] exp_rd[$];
    logic          exp_done[$];
    wbeat_t        wr_q[$];
    logic [BW-1:0] shadow[DEPTH];

    function automatic logic [BW-1:0] pre_beat(int a);
        logic [BW-1:0] b;
        for (int k = 0; k < NM; k++) b[k*W +: W] = 16'hC000 | 16'(k << 10) | 16'(a);
        return b;
    endfunction

    function automatic logic [BW-1:0] wr_beat(int a, int seed);
        logic [BW-1:0] b;
        for (int k = 0; k < NM; k++) b[k*W +: W] = 16'(k << 12) | 16'((a ^ seed) & 'hFFF);
        return b;
    endfunction

    // Banked memory: combinational read, write on the acking edge.
    logic [W-1:0] bank_mem[NM][DEPTH];
    bit           written[NM][DEPTH];

    always @(posedge clk) begin
        for (int k = 0; k < NM; k++) begin
            if (bus.mem_valid[k] && bus.mem_ready[k] && bus.mem_wr_rd) begin
                bank_mem[k][bus.mem_addr] <= bus.mem_wdata[k*W +: W];
                written[k][bus.mem_addr]  <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.mem_rdata = '0;
        for (int k = 0; k < NM; k++) begin
            bus.mem_rdata[k*W +: W] = written[k][bus.mem_addr] ? bank_mem[k][bus.mem_addr]
                                    : (16'hC000 | 16'(k << 10) | 16'(bus.mem_addr));
        end
    end

    // Write-data source: gap counts FETCH cycles held low before offering.
    initial begin
        bit fire;
        fire = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        forever begin
            @(negedge clk);
            if (fire && wr_q.size() > 0) void'(wr_q.pop_front());
            fire = 1'b0;
            if (wr_q.size() == 0) begin
                bus.wr_valid = 1'b0;
            end else if (wr_q[0].gap > 0) begin
                bus.wr_valid = 1'b0;
                if (bus.wr_ready) wr_q[0].gap = wr_q[0].gap - 1;
            end else begin
                bus.wr_valid = 1'b1;
                bus.wr_data  = wr_q[0].data;
                fire         = bus.wr_ready;
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        logic [BW-1:0] e;
        logic          ee;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.rd_valid) begin
                    n_vec++;
                    if (exp_rd.size() == 0) begin
                        n_err++;
                        $display("FAIL rd_unexpected: got %h, none expected", bus.rd_data);
                    end else begin
                        e = exp_rd.pop_front();
                        if (bus.rd_data !== e) begin
                            n_err++;
                            $display("FAIL rd_data: got %h expected %h", bus.rd_data, e);
                        end
                    end
                end
                if (bus.done) begin
                    n_vec++;
                    if (exp_done.size() == 0) begin
                        n_err++;
                        $display("FAIL done_unexpected: got done=1 err=%b, none expected", bus.err);
                    end else begin
                        ee = exp_done.pop_front();
                        if (bus.err !== ee || exp_rd.size() != 0) begin
                            n_err++;
                            $display("FAIL done_err: got err=%b pending_rd=%0d expected err=%b pending_rd=0",
                                     bus.err, exp_rd.size(), ee);
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic issue_cmd(input logic wr, input int addr, input int len);
        int t;
        t = 0;
        while (bus.cmd_ready !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (bus.cmd_ready !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL cmd_ready_wait: got cmd_ready=%b expected 1", bus.cmd_ready);
        end
        bus.cmd_wr_rd = wr;
        bus.cmd_addr  = AS'(addr);
        bus.cmd_len   = AS'(len);
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        if (bus.done !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL done_wait: got done=%b expected 1 within %0d cycles", bus.done, limit);
        end
    endtask

    task automatic push_read(input int addr, input int len);
        for (int i = 0; i <= len; i++) exp_rd.push_back(shadow[(addr + i) % DEPTH]);
        exp_done.push_back(1'b0);
    endtask

    task automatic push_write(input int addr, input int len, input int seed,
                              input int gap_beat, input int gap);
        wbeat_t wb;
        int     a;
        for (int i = 0; i <= len; i++) begin
            a         = (addr + i) % DEPTH;
            wb.data   = wr_beat(a, seed);
            wb.gap    = (i == gap_beat) ? gap : 0;
            shadow[a] = wb.data;
            wr_q.push_back(wb);
        end
        exp_done.push_back(1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int fetch_n;
        int exp_a;

        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_wr_rd = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.mem_ready = '1;
        for (int a = 0; a < DEPTH; a++) shadow[a] = pre_beat(a);

        @(negedge clk);
        check("rst_cmd_ready", BW'(bus.cmd_ready), BW'(1));
        check("rst_status", BW'({bus.busy, bus.done, bus.err, bus.wr_ready, bus.rd_valid, bus.mem_wr_rd}), '0);
        check("rst_mem_valid", BW'(bus.mem_valid), '0);
        check("rst_mem_addr", BW'(bus.mem_addr), '0);
        check("rst_mem_wdata", bus.mem_wdata, '0);
        check("rst_rd_data", bus.rd_data, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Full write 0..255 then read back: 2 cycles/beat, 1 cycle/beat.
        push_write(0, 255, 'h5A5, -1, 0);
        issue_cmd(1'b1, 0, 255);
        check("wr_mem_wr_rd", BW'(bus.mem_wr_rd), BW'(1));
        wait_done(2000, cyc);
        check("wr256_done_cycle", BW'(cyc), BW'(513));
        push_read(0, 255);
        issue_cmd(1'b0, 0, 255);
        wait_done(2000, cyc);
        check("rd256_done_cycle", BW'(cyc), BW'(257));

        // Address wrap 384..511 -> 0..127.
        push_read(384, 255);
        issue_cmd(1'b0, 384, 255);
        wait_done(2000, cyc);
        check("wrap_done_cycle", BW'(cyc), BW'(257));

        // Staggered bank acks on a single-beat read.
        bus.mem_ready = 4'b0000;
        push_read(5, 0);
        issue_cmd(1'b0, 5, 0);
        check("stag_c1", BW'(bus.mem_valid), BW'(4'b1111));
        bus.mem_ready = 4'b0001;
        @(negedge clk);
        check("stag_c2", BW'(bus.mem_valid), BW'(4'b1110));
        bus.mem_ready = 4'b0110;
        @(negedge clk);
        check("stag_c3", BW'(bus.mem_valid), BW'(4'b1000));
        check("stag_addr", BW'(bus.mem_addr), BW'(5));
        bus.mem_ready = 4'b0000;
        @(negedge clk);
        check("stag_c4", BW'(bus.mem_valid), BW'(4'b1000));
        bus.mem_ready = 4'b1000;
        @(negedge clk);
        check("stag_c5", BW'(bus.mem_valid), BW'(4'b0000));
        check("stag_done", BW'(bus.done), BW'(1));
        bus.mem_ready = '1;

        // Write stall: beat 2 held off for 5 FETCH cycles.
        push_write(100, 3, 'h3C, 2, 5);
        issue_cmd(1'b1, 100, 3);
        cyc     = 1;
        fetch_n = 0;
        exp_a   = 100;
        while (bus.done !== 1'b1 && cyc < 100) begin
            if (bus.wr_ready) begin
                fetch_n++;
                check("stall_mem_valid", BW'(bus.mem_valid), '0);
                check("stall_mem_addr", BW'(bus.mem_addr), BW'(exp_a));
            end else if (bus.mem_valid != '0) begin
                exp_a++;
            end
            @(negedge clk);
            cyc++;
        end
        check("stall_done_cycle", BW'(cyc), BW'(14));
        check("stall_fetch_cycles", BW'(fetch_n), BW'(9));
        push_read(98, 7);
        issue_cmd(1'b0, 98, 7);
        wait_done(100, cyc);
        check("stall_rb_done_cycle", BW'(cyc), BW'(9));

        // Reset during beat 10 of 20.
        push_read(0, 19);
        issue_cmd(1'b0, 0, 19);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_cmd_ready", BW'(bus.cmd_ready), BW'(1));
        check("arst_status", BW'({bus.busy, bus.done, bus.rd_valid}), '0);
        check("arst_mem_valid", BW'(bus.mem_valid), '0);
        check("arst_mem_addr", BW'(bus.mem_addr), '0);
        check("arst_rd_data", bus.rd_data, '0);
        exp_rd.delete();
        exp_done.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("arst_no_done", BW'(bus.done), '0);
        end
        push_read(7, 1);
        issue_cmd(1'b0, 7, 1);
        wait_done(100, cyc);
        check("post_rst_done_cycle", BW'(cyc), BW'(3));

        // Bank 2 never acks.
        bus.mem_ready = 4'b1011;
`ifdef MEM_BURST_TIMEOUT_EN
        exp_done.push_back(1'b1);
        issue_cmd(1'b0, 3, 4);
        for (int c = 2; c <= 8; c++) @(negedge clk);
        check("tmo_c8_mem_valid", BW'(bus.mem_valid), BW'(4'b0100));
        @(negedge clk);
        check("tmo_c9_mem_valid", BW'(bus.mem_valid), '0);
        check("tmo_c9_done_err", BW'({bus.done, bus.err}), BW'(2'b11));
        bus.mem_ready = '1;
        @(negedge clk);
        @(negedge clk);
        check("tmo_idle", BW'({bus.busy, bus.cmd_ready}), BW'(2'b01));
`else
        push_read(3, 4);
        issue_cmd(1'b0, 3, 4);
        @(negedge clk);
        check("hang_c2_mem_valid", BW'(bus.mem_valid), BW'(4'b0100));
        for (int c = 3; c <= 20; c++) @(negedge clk);
        check("hang_c20_mem_valid", BW'(bus.mem_valid), BW'(4'b0100));
        check("hang_c20_busy_err", BW'({bus.busy, bus.err}), BW'(2'b10));
        bus.mem_ready = '1;
        wait_done(100, cyc);
        check("hang_release_done_cycle", BW'(cyc), BW'(6));
`endif
        repeat (3) @(negedge clk);

        check("end_rd_queue_empty", BW'(exp_rd.size()), '0);
        check("end_done_queue_empty", BW'(exp_done.size()), '0);
        check("end_wr_queue_empty", BW'(wr_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_burst_ctrl.md
# mem_burst_ctrl

Burst sequencer that drives the `memory_wrapper` banked memory (NUM_MEMS parallel banks sharing one address) from a single command port. It accepts a start address, a beat count and a direction, then walks the address range one beat at a time using the per-bank valid/ready handshake. Write beats are fetched from a streaming source, and read beats are delivered as a streaming output. It sits between a DMA/host command source and `memory_wrapper`, replacing hand-sequenced bench tasks in system-level use.

## Interface
- NUM_MEMS, 4, number of banks (valid/ready lanes)
- WIDTH, 16, data width per bank
- ADDR_SIZE, 9, address width
- DEPTH, 512, words per bank; need not be a power of two
- TIMEOUT, 255, per-beat ack timeout in cycles (used only with MEM_BURST_TIMEOUT_EN)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_wr_rd  in  1  1=write burst, 0=read burst
- cmd_addr  in  ADDR_SIZE  start address, must be < DEPTH
- cmd_len  in  ADDR_SIZE  beats minus one (0 → 1 beat)
- wr_valid  in  1  write data offered
- wr_ready  out  1  write data accepted
- wr_data  in  NUM_MEMS*WIDTH  write beat, bank k in slice k
- rd_valid  out  1  one-cycle read-beat strobe, no backpressure
- rd_data  out  NUM_MEMS*WIDTH  read beat
- busy  out  1  not IDLE
- done  out  1  one-cycle end-of-burst pulse
- err  out  1  qualifies done; timeout abort
- mem_addr  out  ADDR_SIZE  to wrapper addr
- mem_wr_rd  out  1  to wrapper wr_rd
- mem_wdata  out  NUM_MEMS*WIDTH  to wrapper wdata
- mem_rdata  in  NUM_MEMS*WIDTH  from wrapper rdata
- mem_valid  out  NUM_MEMS  per-bank request
- mem_ready  in  NUM_MEMS  per-bank ack

## Operation
- States are IDLE, FETCH, XFER and DONE.
- IDLE: on cmd_valid, latch the command. Set addr=cmd_addr and remaining=cmd_len+1 (ADDR_SIZE+1 bits). Go to FETCH if write, otherwise XFER.
- FETCH: wr_ready=1. When wr_valid is high, latch wr_data into mem_wdata and go to XFER.
- XFER: mem_valid[k] = ~ack_mask[k]. A bank acks when mem_valid[k] & mem_ready[k]; that sets ack_mask[k], and on reads captures mem_rdata slice k into rd_data slice k on the same edge.
- A beat completes when (ack_mask | (mem_valid & mem_ready)) is all ones. On completion:
  - clear ack_mask
  - decrement remaining
  - advance addr, wrapping DEPTH-1 → 0
  - for reads, pulse rd_valid the next cycle
- After a completed beat:
  - if remaining reaches 0, go to DONE
  - otherwise go to FETCH (write) or stay in XFER (read)
- DONE: done=1 for one cycle, then IDLE.
- mem_wr_rd is held for the whole burst. mem_addr and mem_wdata are stable while any mem_valid bit is high.
- Banks acking on different cycles are legal. An acked bank sees its valid drop and is not re-requested.
- A command is never accepted while busy; cmd_valid is ignored outside IDLE.

## Timing
- Reset (async assert, sync deassert) gives:
  - state=IDLE, cmd_ready=1
  - all other outputs 0, including mem_valid, rd_data, mem_addr and mem_wdata
  - ack_mask and counters cleared
- Reset mid-burst aborts immediately: no done pulse, and partial beats are lost.
- Handshake timing with all banks ready every cycle:
  - read: 1 cycle per beat
  - write: 2 cycles per beat (FETCH + XFER)
- Burst latency is as follows:
  - cmd accept to first mem_valid: 1 cycle for reads, or 1 cycle after wr_valid for writes
  - last beat ack to done: 1 cycle
  - the last beat's rd_valid coincides with done
- cmd_len = 2^ADDR_SIZE-1 with DEPTH smaller wraps the address repeatedly. This is legal and is not an error.

## Configuration
- Macro: MEM_BURST_TIMEOUT_EN.
- Defined: a per-beat counter runs in XFER and resets on each beat completion. If it reaches TIMEOUT with the mask incomplete:
  - all mem_valid drop next edge
  - state → DONE
  - done and err pulse together
  - remaining beats are abandoned and no rd_valid is issued for the aborted beat
- Undefined: no counter, err tied 0, and XFER waits indefinitely.

## Test plan
- Write burst: addr=0, len=255, wr_valid always 1, mem_ready all ones → 256 beats, mem_addr 0..255, done at cycle ~513, err=0. A following read burst with the same addr/len returns 256 rd_valid beats matching the written data.
- Wrap: read with addr=384, len=255, DEPTH=512 → mem_addr 384..511 then 0..127, 256 rd_valid strobes.
- Staggered acks: bank 0 ready on cycle 1, bank 3 on cycle 4, others on cycle 2 → mem_valid goes 1111→1110→1000→0000. A single rd_valid is issued with all four slices correct.
- Write stall: wr_valid low for 5 cycles mid-burst → mem_valid stays 0000 while in FETCH, and mem_addr does not advance.
- Reset mid-burst: rst asserted during beat 10 of 20 → outputs are 0 asynchronously, no done. A new command after release starts cleanly.
- With MEM_BURST_TIMEOUT_EN and TIMEOUT=8: bank 2 ready held low → after 8 XFER cycles, done=1 and err=1, mem_valid=0000. Without the macro, the controller stays in XFER with busy=1.
